// File: rtl/video_encoder_ctrl_pkg.sv
// Shared definitions for the multi-channel video encoder control block:
// sequencer states, register bit positions and ZXUNO register addresses.
package video_encoder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_SETTLE = 2'd2
  } seq_state_t;

  localparam int unsigned MODE_BIT     = 0;
  localparam int unsigned COLORCLK_BIT = 1;
  localparam int unsigned BUSY_BIT     = 7;

  // ZXUNO register map (subset)
  localparam logic [7:0] REG_MASTERCONF  = 8'h00;
  localparam logic [7:0] REG_SCANDBLCTRL = 8'h0B;
  localparam logic [7:0] REG_RASTERLINE  = 8'h0C;
  localparam logic [7:0] REG_AD724       = 8'hFB;

  localparam logic [7:0] DEFAULT_BASE_ADDR = REG_AD724;

endpackage

// File: rtl/video_encoder_ctrl_if.sv
// ZXUNO register bus as seen by one register block.
interface video_encoder_ctrl_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe;

  modport master (
    output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    input  dout, oe
  );

  modport slave (
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    output dout, oe
  );
endinterface

// File: rtl/video_encoder_ctrl_chan.sv
// One encoder channel: shadow register, applied mode and the
// blank / switch / settle sequencer that retunes the encoder glitch-free.
module encoder_chan_seq
  import video_encoder_ctrl_pkg::*;
#(
  parameter logic [7:0]  RESET_VAL     = 8'h00,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       poweron_rst,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  output logic [6:0] shadow,
  output logic       busy,
  output logic       enc_mode,
  output logic       enc_xtal,
  output logic       enc_gencolorclk,
  output logic       enc_blank
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             applied_mode, applied_nxt;

  always_ff @(posedge clk) begin
    if (poweron_rst) begin
      shadow       <= RESET_VAL[6:0];
      applied_mode <= RESET_VAL[MODE_BIT];
      state        <= ST_IDLE;
      cnt          <= '0;
    end else begin
      if (wr_en) shadow <= wr_data;
      applied_mode <= applied_nxt;
      state        <= state_nxt;
      cnt          <= cnt_nxt;
    end
  end

  // Writes landing mid-sequence only touch the shadow; any leftover
  // mismatch is picked up from IDLE once the current sequence finishes.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    applied_nxt     = applied_mode;
    enc_blank       = 1'b1;
    enc_gencolorclk = 1'b0;
    case (state)
      ST_IDLE: begin
        enc_blank       = 1'b0;
        enc_gencolorclk = shadow[COLORCLK_BIT];
        if (shadow[MODE_BIT] != applied_mode) state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        applied_nxt = shadow[MODE_BIT];
        cnt_nxt     = SETTLE_LOAD;
        state_nxt   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) state_nxt = ST_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign enc_mode = applied_mode;
  assign enc_xtal = ~applied_mode;

endmodule

// File: rtl/video_encoder_ctrl.sv
// NUM_CH encoder-control registers on the ZXUNO bus at BASE_ADDR+i,
// each driving its own encoder channel sequencer.
module video_encoder_ctrl
  import video_encoder_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter logic [7:0]  BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter logic [7:0]  RESET_VAL     = 8'h00,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                poweron_rst,
  video_encoder_ctrl_if.slave zxuno,
  output logic [NUM_CH-1:0]   enc_xtal,
  output logic [NUM_CH-1:0]   enc_mode,
  output logic [NUM_CH-1:0]   enc_gencolorclk,
  output logic [NUM_CH-1:0]   enc_blank,
  output logic [NUM_CH-1:0]   busy
);

  // Decode in 9 bits so a block ending past 8'hFF cannot alias low addresses.
  localparam logic [8:0] BASE9 = {1'b0, BASE_ADDR};

  logic [8:0]        addr9;
  logic [NUM_CH-1:0] sel;
  logic [6:0]        shadow [NUM_CH];
  logic [7:0]        rd_data;
  logic              unused_din7;

  assign addr9       = {1'b0, zxuno.zxuno_addr};
  assign unused_din7 = zxuno.din[BUSY_BIT];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel[g] = (addr9 == BASE9 + 9'(g));

    encoder_chan_seq #(
      .RESET_VAL     (RESET_VAL),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk             (clk),
      .poweron_rst     (poweron_rst),
      .wr_en           (zxuno.zxuno_regwr & sel[g]),
      .wr_data         (zxuno.din[6:0]),
      .shadow          (shadow[g]),
      .busy            (busy[g]),
      .enc_mode        (enc_mode[g]),
      .enc_xtal        (enc_xtal[g]),
      .enc_gencolorclk (enc_gencolorclk[g]),
      .enc_blank       (enc_blank[g])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel[i]) rd_data = {busy[i], shadow[i]};
    end
  end

  assign zxuno.dout = rd_data;
  assign zxuno.oe   = zxuno.zxuno_regrd & (|sel);

endmodule
